// File: rtl/trig_pkg.sv
// Shared types and opcode constants for the logIP trigger sequencer.
package trig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      KIND_MASK = 2'd0,
      KIND_VAL  = 2'd1,
      KIND_CFG  = 2'd2
   } kind_e;

   localparam logic [7:0] OPC_RESET      = 8'h00;
   localparam logic [7:0] OPC_ARM        = 8'h01;
   localparam logic [7:0] OPC_STAGE_BASE = 8'hC0;

endpackage

// File: rtl/trig_cmd_dec.sv
// Combinational decode of a SUMP trigger opcode into soft-reset, arm and
// per-stage configuration fields.
module trig_cmd_dec
   import trig_pkg::*;
#(
   parameter int NUM_STAGES = 4
) (
   input  logic [7:0] opc_i,
   output logic       softRst_o,
   output logic       arm_o,
   output logic       cfgValid_o,
   output logic [1:0] kind_o,
   output logic [1:0] stage_o
);

   // Stage opcodes are 0xC0 | (stage << 2) | kind; kind 3 and stages past
   // the instantiated count decode as nothing at all.
   always_comb begin
      softRst_o  = (opc_i == OPC_RESET);
      arm_o      = (opc_i == OPC_ARM);
      kind_o     = opc_i[1:0];
      stage_o    = opc_i[3:2];
      cfgValid_o = (opc_i[7:4] == OPC_STAGE_BASE[7:4])
                   && (opc_i[1:0] != 2'd3)
                   && (int'(opc_i[3:2]) < NUM_STAGES);
   end

endmodule

// File: rtl/trig_ctrl.sv
// Trigger sequencer: turns decoded commands into registered stage strobes,
// tracks the shared trigger level and raises a sticky run request.
module trig_ctrl
   import trig_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int LVL_W      = 2,
   parameter int DATA_W     = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_in,
   input  logic                  exec_i,
   input  logic [7:0]            opc_i,
   input  logic [DATA_W-1:0]     data_i,
   input  logic                  stb_i,
   input  logic [NUM_STAGES-1:0] match_i,
   input  logic [NUM_STAGES-1:0] run_i,
   input  logic                  done_i,
   output logic [DATA_W-1:0]     cmd_o,
   output logic [NUM_STAGES-1:0] set_mask_o,
   output logic [NUM_STAGES-1:0] set_val_o,
   output logic [NUM_STAGES-1:0] set_cfg_o,
   output logic                  arm_o,
   output logic [LVL_W-1:0]      lvl_o,
   output logic                  run_o,
   output logic                  armed_o,
   output logic                  cmd_err_o
);

   logic                  decSoftRst;
   logic                  decArm;
   logic                  decCfgValid;
   logic [1:0]            decKind;
   logic [1:0]            decStage;
   logic [NUM_STAGES-1:0] stageHot;

   state_e                state_q,   state_d;
   logic [LVL_W-1:0]      lvl_q,     lvl_d;
   logic [DATA_W-1:0]     cmd_q,     cmd_d;
   logic [NUM_STAGES-1:0] setMask_q, setMask_d;
   logic [NUM_STAGES-1:0] setVal_q,  setVal_d;
   logic [NUM_STAGES-1:0] setCfg_q,  setCfg_d;
   logic                  armPulse_q, armPulse_d;
   logic                  cmdErr_q,   cmdErr_d;

   trig_cmd_dec #(
      .NUM_STAGES (NUM_STAGES)
   ) u_dec (
      .opc_i      (opc_i),
      .softRst_o  (decSoftRst),
      .arm_o      (decArm),
      .cfgValid_o (decCfgValid),
      .kind_o     (decKind),
      .stage_o    (decStage)
   );

   assign stageHot = NUM_STAGES'(1) << decStage;

   // Soft reset wins over everything; otherwise the state case orders
   // done_i over run_i over the level increment.
   always_comb begin
      state_d    = state_q;
      lvl_d      = lvl_q;
      cmd_d      = cmd_q;
      setMask_d  = '0;
      setVal_d   = '0;
      setCfg_d   = '0;
      armPulse_d = 1'b0;
      cmdErr_d   = 1'b0;

      if (exec_i && decSoftRst) begin
         state_d = ST_IDLE;
         lvl_d   = '0;
      end else begin
         if (exec_i && decCfgValid) begin
            if (state_q == ST_IDLE) begin
               cmd_d = data_i;
               case (decKind)
                  KIND_MASK: setMask_d = stageHot;
                  KIND_VAL:  setVal_d  = stageHot;
                  KIND_CFG:  setCfg_d  = stageHot;
                  default:   ;
               endcase
            end else begin
               cmdErr_d = 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (exec_i && decArm) begin
                  armPulse_d = 1'b1;
                  lvl_d      = '0;
                  state_d    = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (|run_i) begin
                  state_d = ST_RUN;
               end else if (stb_i && (|match_i) && (lvl_q != '1)) begin
                  lvl_d = lvl_q + LVL_W'(1);
               end
            end
            ST_RUN: begin
               if (done_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         lvl_q      <= '0;
         cmd_q      <= '0;
         setMask_q  <= '0;
         setVal_q   <= '0;
         setCfg_q   <= '0;
         armPulse_q <= 1'b0;
         cmdErr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lvl_q      <= lvl_d;
         cmd_q      <= cmd_d;
         setMask_q  <= setMask_d;
         setVal_q   <= setVal_d;
         setCfg_q   <= setCfg_d;
         armPulse_q <= armPulse_d;
         cmdErr_q   <= cmdErr_d;
      end
   end

   assign cmd_o      = cmd_q;
   assign set_mask_o = setMask_q;
   assign set_val_o  = setVal_q;
   assign set_cfg_o  = setCfg_q;
   assign arm_o      = armPulse_q;
   assign lvl_o      = lvl_q;
   assign run_o      = (state_q == ST_RUN);
   assign armed_o    = (state_q == ST_ARMED);
   assign cmd_err_o  = cmdErr_q;

endmodule

// File: tb/tb_trig_ctrl.sv
// Scoreboard bench for trig_ctrl: directed command sequences plus random
// traffic, checked against a command-level reference model.
module tb_trig_ctrl;

   localparam int NS      = 4;
   localparam int LW      = 2;
   localparam int DW      = 32;
   localparam int LVL_MAX = (1 << LW) - 1;

   typedef struct packed {
      logic [31:0] cmd;
      logic [3:0]  sm;
      logic [3:0]  sv;
      logic [3:0]  sc;
      logic        arm;
      logic [1:0]  lvl;
      logic        run;
      logic        armed;
      logic        err;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rst_in = 1'b0;
   logic          exec_i = 1'b0;
   logic [7:0]    opc_i = '0;
   logic [DW-1:0] data_i = '0;
   logic          stb_i = 1'b0;
   logic [NS-1:0] match_i = '0;
   logic [NS-1:0] run_i = '0;
   logic          done_i = 1'b0;
   logic [DW-1:0] cmd_o;
   logic [NS-1:0] set_mask_o, set_val_o, set_cfg_o;
   logic          arm_o, run_o, armed_o, cmd_err_o;
   logic [LW-1:0] lvl_o;

   int checks = 0;
   int failures = 0;
   exp_t expQ[$];

   // Reference model: 0 = idle, 1 = armed, 2 = capturing
   int          mState = 0;
   int          mLvl = 0;
   logic [31:0] mCmd = '0;

   trig_ctrl #(.NUM_STAGES(NS), .LVL_W(LW), .DATA_W(DW)) dut (
      .clk_i      (clk_i),
      .rst_in     (rst_in),
      .exec_i     (exec_i),
      .opc_i      (opc_i),
      .data_i     (data_i),
      .stb_i      (stb_i),
      .match_i    (match_i),
      .run_i      (run_i),
      .done_i     (done_i),
      .cmd_o      (cmd_o),
      .set_mask_o (set_mask_o),
      .set_val_o  (set_val_o),
      .set_cfg_o  (set_cfg_o),
      .arm_o      (arm_o),
      .lvl_o      (lvl_o),
      .run_o      (run_o),
      .armed_o    (armed_o),
      .cmd_err_o  (cmd_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cmpField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmpField("cmd_o",      cmd_o,      e.cmd);
      cmpField("set_mask_o", 32'(set_mask_o), 32'(e.sm));
      cmpField("set_val_o",  32'(set_val_o),  32'(e.sv));
      cmpField("set_cfg_o",  32'(set_cfg_o),  32'(e.sc));
      cmpField("arm_o",      32'(arm_o),      32'(e.arm));
      cmpField("lvl_o",      32'(lvl_o),      32'(e.lvl));
      cmpField("run_o",      32'(run_o),      32'(e.run));
      cmpField("armed_o",    32'(armed_o),    32'(e.armed));
      cmpField("cmd_err_o",  32'(cmd_err_o),  32'(e.err));
   endtask

   // Drives one cycle of inputs, advances the model and queues the outputs
   // expected right after the next rising edge.
   task automatic applyStimulus(input logic ex, input logic [7:0] op, input logic [31:0] d,
                                input logic st, input logic [3:0] ma, input logic [3:0] ru,
                                input logic dn);
      exp_t e;
      int   k;
      int   s;
      exec_i = ex; opc_i = op; data_i = d; stb_i = st;
      match_i = ma; run_i = ru; done_i = dn;
      e = '0;
      k = int'(op[1:0]);
      s = int'(op[3:2]);
      if (ex && op == 8'h00) begin
         mState = 0;
         mLvl   = 0;
      end else begin
         if (ex && op[7:4] == 4'hC && k != 3 && s < NS) begin
            if (mState == 0) begin
               mCmd = d;
               if (k == 0) e.sm = 4'b0001 << s;
               if (k == 1) e.sv = 4'b0001 << s;
               if (k == 2) e.sc = 4'b0001 << s;
            end else begin
               e.err = 1'b1;
            end
         end
         if (ex && op == 8'h01 && mState == 0) begin
            e.arm  = 1'b1;
            mLvl   = 0;
            mState = 1;
         end else if (mState == 2 && dn) begin
            mState = 0;
         end else if (mState == 1 && ru != 0) begin
            mState = 2;
         end else if (mState == 1 && st && ma != 0 && mLvl < LVL_MAX) begin
            mLvl++;
         end
      end
      e.cmd   = mCmd;
      e.lvl   = 2'(mLvl);
      e.run   = (mState == 2);
      e.armed = (mState == 1);
      expQ.push_back(e);
      @(negedge clk_i);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 8'hFF, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   // Monitor: compares the DUT against the oldest queued expectation
   always @(posedge clk_i) begin
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   initial begin
      exp_t zero;
      int   budget;
      logic [7:0] op;
      zero = '0;
      repeat (3) @(negedge clk_i);
      checkOutput(zero);
      rst_in = 1'b1;

      // Config in idle, then arm and a rejected config
      applyStimulus(1'b1, 8'hC5, 32'hDEADBEEF, 1'b0, 4'h0, 4'h0, 1'b0);
      idleCycle();
      applyStimulus(1'b1, 8'h01, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0);
      idleCycle();
      applyStimulus(1'b1, 8'hC0, 32'h12345678, 1'b0, 4'h0, 4'h0, 1'b0);
      idleCycle();
      // Level counting with saturation, then matches without strobe
      repeat (4) applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 4'b0011, 4'h0, 1'b0);
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 4'b1111, 4'h0, 1'b0);
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 4'h0, 4'b0100, 1'b0);
      idleCycle();
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 4'h0, 4'h0, 1'b1);
      idleCycle();
      // Soft reset and done together while capturing
      applyStimulus(1'b1, 8'h01, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0);
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 4'b0001, 4'h0, 1'b0);
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 4'h0, 4'b0001, 1'b0);
      applyStimulus(1'b1, 8'h00, 32'h0, 1'b0, 4'h0, 4'h0, 1'b1);
      idleCycle();
      // Ignored stage opcodes, a valid stage-3 config, arm alongside run_i
      applyStimulus(1'b1, 8'hCF, 32'h11111111, 1'b0, 4'h0, 4'h0, 1'b0);
      applyStimulus(1'b1, 8'hC3, 32'h22222222, 1'b0, 4'h0, 4'h0, 1'b0);
      applyStimulus(1'b1, 8'hCE, 32'h33333333, 1'b0, 4'h0, 4'h0, 1'b0);
      applyStimulus(1'b1, 8'h01, 32'h0, 1'b1, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 4'h0, 4'b1000, 1'b0);
      idleCycle();

      // Asynchronous reset while the run request is high
      #2;
      cmpField("pre_reset_run_o", 32'(run_o), 32'(mState == 2));
      rst_in = 1'b0;
      #1;
      checkOutput(zero);
      mState = 0; mLvl = 0; mCmd = '0;
      @(negedge clk_i);
      rst_in = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         int sel;
         logic ex;
         sel = int'($urandom_range(0, 19));
         ex  = 1'b1;
         if (sel == 0)      op = 8'h00;
         else if (sel < 4)  op = 8'h01;
         else if (sel < 10) op = 8'hC0 | 8'($urandom_range(0, 15));
         else if (sel < 11) op = 8'($urandom);
         else begin op = 8'($urandom); ex = 1'b0; end
         applyStimulus(ex, op, $urandom, 1'($urandom), 4'($urandom),
                       ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
                       ($urandom_range(0, 7) == 0));
      end
      exec_i = 1'b0;

      budget = 20;
      while (expQ.size() > 0 && budget > 0) begin
         @(posedge clk_i);
         budget--;
      end
      #2;
      if (expQ.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain actual=%0d expected=0 entries left", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trig_ctrl.md
Name: trig_ctrl

Overview:
Trigger sequencer for the logIP trigger pipeline. It decodes SUMP trigger commands into per-stage set strobes and arms all stages. It tracks the shared trigger level fed to every stage's lvl_i and collects stage run outputs into a single sticky run request for the sampler. It sits between the command receiver and the NUM_STAGES stage instances.

Parameters:
NUM_STAGES, 4, number of trigger stages controlled (1..4, so the stage index fits opcode bits [3:2])
LVL_W, 2, width of the trigger level counter
DATA_W, 32, command payload width

Ports:
clk_i  in  1  system clock
rst_in  in  1  asynchronous active-low reset
exec_i  in  1  one-cycle command-valid pulse
opc_i  in  8  command opcode
data_i  in  DATA_W  command payload
stb_i  in  1  sample strobe, aligned with the samples the stages see
match_i  in  NUM_STAGES  per-stage match_o
run_i  in  NUM_STAGES  per-stage run_o
done_i  in  1  sampler capture complete
cmd_o  out  DATA_W  registered payload to all stages' cmd_i
set_mask_o  out  NUM_STAGES  one-hot set_mask_i pulses
set_val_o  out  NUM_STAGES  one-hot set_val_i pulses
set_cfg_o  out  NUM_STAGES  one-hot set_cfg_i pulses
arm_o  out  1  arm pulse to all stages' arm_i
lvl_o  out  LVL_W  current trigger level to all stages' lvl_i
run_o  out  1  sticky capture-run request to sampler
armed_o  out  1  high in ARMED state
cmd_err_o  out  1  one-cycle pulse: config command rejected

Behaviour:
- Clock clk_i; reset rst_in is asynchronous, active-low. Reset values: all outputs 0, state IDLE, level 0.
- FSM states: IDLE, ARMED, RUN.
- Opcode decode applies only when exec_i=1. Unknown opcodes are ignored.
  - 0x00: soft reset.
  - 0x01: arm.
  - 0xC0 | (s<<2) | k, with s<NUM_STAGES: k=0 mask, k=1 value, k=2 config. k=3 or s>=NUM_STAGES is ignored.
- Config commands:
  - Accepted in IDLE only. One cycle later, the matching set_*_o[s] pulses for exactly 1 cycle and cmd_o holds data_i.
  - cmd_o keeps its value until the next accepted config command.
  - In ARMED or RUN, no set pulse is issued and cmd_err_o pulses 1 cycle (latency 1).
- Arm:
  - In IDLE: the next cycle has arm_o=1 for 1 cycle, level cleared to 0, state ARMED.
  - In ARMED or RUN: ignored, no error.
- Level (ARMED only):
  - On stb_i=1 with |match_i, level increments by 1, saturating at 2^LVL_W-1.
  - Several matches in the same cycle still count +1.
  - Without stb_i, matches are ignored. lvl_o is the level register.
- ARMED -> RUN: any run_i bit high. The next cycle has run_o=1, armed_o=0. The level freezes.
- RUN -> IDLE: on done_i. run_o clears the next cycle; the level is held until the next arm.
- done_i in IDLE or ARMED is ignored.
- Soft reset from any state: next cycle state IDLE, level 0, run_o 0, pending pulses cancelled.
- Priority within one cycle: soft reset > done_i > run_i > level increment.
- Arm in the same cycle as run_i: state is IDLE, so run_i is ignored.
- Asynchronous reset mid-capture: immediate return to reset values. Stages are not re-armed.

Decomposition:
- Package trig_pkg:
  - state enum (IDLE, ARMED, RUN)
  - opcode constants OPC_RESET=8'h00, OPC_ARM=8'h01, OPC_STAGE_BASE=8'hC0
  - stage-field kind enum (MASK, VAL, CFG)
- Natural sub-module trig_cmd_dec: combinational opcode -> {soft_rst, arm, kind, stage idx, valid}, wrapped by registered pulse generation in trig_ctrl.

Test Plan:
- Reset, then in IDLE exec opc=0xC5, data=0xDEADBEEF -> 1 cycle later set_val_o=4'b0010 for 1 cycle, cmd_o=0xDEADBEEF, cmd_err_o=0.
- opc=0x01 -> arm_o pulse 1 cycle, armed_o=1. Then opc=0xC0 -> cmd_err_o pulse, set_mask_o stays 0.
- ARMED, match_i=4'b0011 with stb_i for 4 strobes, LVL_W=2 -> lvl_o 1,2,3,3 (saturation). match_i without stb_i -> no change.
- ARMED, run_i=4'b0100 -> run_o=1 next cycle, armed_o=0. done_i -> run_o=0, state IDLE, lvl_o held.
- RUN, exec opc=0x00 and done_i in the same cycle -> IDLE, lvl_o=0, run_o=0.
- opc=0xCF with NUM_STAGES=3 and opc=0xC3 -> no set pulses, no error. rst_in low while run_o=1 -> all outputs 0 immediately.
